// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART TX-side stream blocks.
//
// Contents:
//   arb_state_e      - arbiter FSM encoding (IDLE, HEADER, STREAM)
//   HDR_MAX_W        - widest word make_src_header can build
//   make_src_header  - builds the source-id header word {1'b1, id}. The caller
//                      truncates the result to its own word width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'h0,
    HEADER = 2'h1,
    STREAM = 2'h2
  } arb_state_e;

  localparam int unsigned HDR_MAX_W = 32;

  // Sets the top bit of a word_width-bit word and puts the id in the low bits.
  // The id must fit in word_width-1 bits, so it cannot overlap the marker bit.
  function automatic logic [HDR_MAX_W-1:0] make_src_header(
    input logic [HDR_MAX_W-1:0] id,
    input int unsigned          word_width
  );
    logic [HDR_MAX_W-1:0] hdr;
    hdr = id;
    hdr[word_width-1] = 1'b1;
    return hdr;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick.
//
// Searches the request vector upward from last_i+1, wrapping modulo N.
// It returns the first set bit. The search order makes last_i the lowest
// priority on the next pick.
//
// Ports:
//   req_i       [N-1:0]          request vector
//   last_i      [$clog2(N)-1:0]  index granted last time
//   any_req_o                    any request bit set
//   pick_idx_o  [$clog2(N)-1:0]  chosen index; 0 when nothing is requested
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 any_req_o,
  output logic [$clog2(N)-1:0] pick_idx_o
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    any_req_o  = |req_i;
    pick_idx_o = '0;
    found      = 1'b0;
    idx        = '0;
    // Offset k = 1 first, so the source granted last time is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        pick_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter's AXI-Stream input between
// NUM_SOURCES AXI-Stream requesters. Arbitration is round-robin and grants
// are held per packet.
//
// A granted source keeps the transmitter until one of two things happens:
// a tlast beat transfers, or MAX_BURST beats have transferred. After each
// grant there is exactly one IDLE cycle, in which the next source is picked.
//
// Optional feature (macro UART_TX_ARBITER_SOURCE_ID_HEADER_EN): each grant is
// preceded by one header word {1'b1, grant_id}. The header does not count
// toward MAX_BURST.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   src_axis_tdata    [NUM_SOURCES*WORD_WIDTH-1:0] source words, source i at [i*W +: W]
//   src_axis_tvalid   [NUM_SOURCES-1:0] per-source valid
//   src_axis_tlast    [NUM_SOURCES-1:0] per-source end of packet
//   src_axis_tready   [NUM_SOURCES-1:0] per-source ready (only the granted bit can be high)
//   dout_axis_tdata   [WORD_WIDTH-1:0]  word to the transmitter
//   dout_axis_tvalid  valid to the transmitter
//   dout_axis_tready  ready from the transmitter
//   grant_id          [$clog2(NUM_SOURCES)-1:0] current or last granted source
//   busy              high in any state other than IDLE
//   dbg_state_o       current FSM state, for observation
//
// Handshake: a beat transfers on a rising edge where tvalid && tready, on
// every AXI-Stream interface. Valid never waits for ready. In STREAM the
// granted source's tvalid/tready/tdata are wired straight through to the
// transmitter, with no pipeline stage in between.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SOURCES*WORD_WIDTH-1:0] src_axis_tdata,
  input  logic [NUM_SOURCES-1:0]            src_axis_tvalid,
  input  logic [NUM_SOURCES-1:0]            src_axis_tlast,
  output logic [NUM_SOURCES-1:0]            src_axis_tready,
  output logic [WORD_WIDTH-1:0]             dout_axis_tdata,
  output logic                              dout_axis_tvalid,
  input  logic                              dout_axis_tready,
  output logic [$clog2(NUM_SOURCES)-1:0]    grant_id,
  output logic                              busy,
  output arb_state_e                        dbg_state_o
);

  localparam int IW = $clog2(NUM_SOURCES);
  localparam int BW = $clog2(MAX_BURST + 1);

  if (NUM_SOURCES < 2 || NUM_SOURCES > 16) begin : g_bad_num_sources
    $error("uart_tx_arbiter: NUM_SOURCES must be in 2..16");
  end
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("uart_tx_arbiter: MAX_BURST must be >= 1");
  end
`ifdef UART_TX_ARBITER_SOURCE_ID_HEADER_EN
  if (NUM_SOURCES > (2 ** (WORD_WIDTH - 1))) begin : g_bad_header_width
    $error("uart_tx_arbiter: source id does not fit beside the header marker bit");
  end
`endif

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;

  logic                  any_req;
  logic [IW-1:0]         pick_idx;
  logic [WORD_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  beat_xfer;
  logic                  burst_full;

  rr_priority_picker #(
    .N (NUM_SOURCES)
  ) u_picker (
    .req_i      (src_axis_tvalid),
    .last_i     (last_q),
    .any_req_o  (any_req),
    .pick_idx_o (pick_idx)
  );

  assign sel_data   = src_axis_tdata[int'(grant_q)*WORD_WIDTH +: WORD_WIDTH];
  assign sel_valid  = src_axis_tvalid[grant_q];
  assign sel_last   = src_axis_tlast[grant_q];
  assign beat_xfer  = sel_valid && dout_axis_tready;
  // The beat now in flight is the MAX_BURST-th of this grant.
  assign burst_full = (beat_q == BW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_SOURCES - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    beat_d           = beat_q;
    dout_axis_tdata  = '0;
    dout_axis_tvalid = 1'b0;
    src_axis_tready  = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_idx;
          beat_d  = '0;
`ifdef UART_TX_ARBITER_SOURCE_ID_HEADER_EN
          state_d = HEADER;
`else
          state_d = STREAM;
`endif
        end
      end

`ifdef UART_TX_ARBITER_SOURCE_ID_HEADER_EN
      HEADER: begin
        dout_axis_tvalid = 1'b1;
        dout_axis_tdata  = WORD_WIDTH'(make_src_header(HDR_MAX_W'(grant_q), WORD_WIDTH));
        if (dout_axis_tready) begin
          state_d = STREAM;
        end
      end
`endif

      STREAM: begin
        dout_axis_tdata           = sel_data;
        dout_axis_tvalid          = sel_valid;
        src_axis_tready[grant_q]  = dout_axis_tready;
        if (beat_xfer) begin
          // tlast on the MAX_BURST-th beat is one release, not two.
          if (sel_last || burst_full) begin
            last_d  = grant_q;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter's AXI-Stream input (WORD_WIDTH-bit words) between NUM_SOURCES AXI-Stream requesters.
- Grants are held at packet level: a source keeps the transmitter until it sends a tlast beat, or until MAX_BURST beats have been sent.
- Sits between the software/host-side stream producers and the serial transmitter. It is the TX-side counterpart of the receiver_axis datapath.

Parameters:
- NUM_SOURCES, 4, number of requesters; legal range 2..16.
- WORD_WIDTH, 8, data bits per word; must match the transmitter.
- MAX_BURST, 16, maximum beats per grant before forced rotation; legal range ≥1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- src_axis_tdata  input  NUM_SOURCES*WORD_WIDTH  source words; source i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
- src_axis_tvalid  input  NUM_SOURCES  per-source valid
- src_axis_tlast  input  NUM_SOURCES  per-source end of packet
- src_axis_tready  output  NUM_SOURCES  per-source ready
- dout_axis_tdata  output  WORD_WIDTH  word to transmitter
- dout_axis_tvalid  output  1  valid to transmitter
- dout_axis_tready  input  1  transmitter ready
- grant_id  output  $clog2(NUM_SOURCES)  index of the current or last granted source
- busy  output  1  high while in any state other than IDLE

Behaviour:
- Clocking and reset
  - All registers are on posedge clk, with asynchronous clear on negedge rst_n.
  - Reset values: state=IDLE, grant_id=0, last_grant=NUM_SOURCES-1 (so source 0 has first priority), beat_cnt=0.
  - Outputs during reset: dout_axis_tvalid=0, src_axis_tready=0, busy=0.
- States: IDLE, HEADER (only when SOURCE_ID_HEADER_EN is defined), STREAM.
- IDLE
  - dout_axis_tvalid=0 and all src_axis_tready=0.
  - If any src_axis_tvalid bit is set, pick the first set bit searching upward from last_grant+1, wrapping modulo NUM_SOURCES.
  - Register the pick into grant_id, clear beat_cnt, and go to STREAM (or HEADER).
  - Arbitration latency is 1 cycle from request to the first dout_axis_tvalid.
- STREAM, with g = grant_id
  - dout_axis_tdata = src word g; dout_axis_tvalid = src_axis_tvalid[g]; src_axis_tready[g] = dout_axis_tready.
  - All other src_axis_tready bits are 0. These paths are combinational; the block inserts no pipeline stage.
  - A beat transfers when src_axis_tvalid[g] && dout_axis_tready; each transfer increments beat_cnt.
  - Release condition: a beat transfers with src_axis_tlast[g]=1, OR beat_cnt+1 == MAX_BURST.
  - On release: last_grant <= g, then go to IDLE.
  - There is always exactly one IDLE cycle between grants.
- Source stalls mid-packet (tvalid low): the grant is held and no other source is served. The lock ends only on tlast or on MAX_BURST.
- Other requesters asserting tvalid during STREAM is ignored until IDLE.
- Single requester: it is re-granted after the one IDLE cycle. Fairness applies only when there is contention.
- beat_cnt width is $clog2(MAX_BURST+1). It does not wrap, because release happens at MAX_BURST.
- MAX_BURST=1: every beat releases the grant.
- tlast on the MAX_BURST-th beat: a single release; no double count.
- Reset mid-packet: dout_axis_tvalid drops immediately (asynchronously). An in-flight word may be lost; this is accepted.
- The transmitter may hold tready low indefinitely; all state is held and tdata stays stable as long as the source obeys AXIS.

Optional Feature:
- Macro: UART_TX_ARBITER_SOURCE_ID_HEADER_EN.
- Defined:
  - IDLE goes to HEADER instead of STREAM.
  - In HEADER, dout_axis_tvalid=1 and dout_axis_tdata = {1'b1, grant_id zero-extended to WORD_WIDTH-1}. All src_axis_tready=0.
  - Leave HEADER for STREAM when dout_axis_tready=1.
  - The header does not count toward MAX_BURST.
  - Requires NUM_SOURCES ≤ 2^(WORD_WIDTH-1); check with an elaboration-time assertion.
- Undefined: the HEADER state and its logic are absent, and IDLE goes directly to STREAM.

Decomposition:
- Package uart_pkg:
  - arbiter state enum (IDLE=2'h0, HEADER=2'h1, STREAM=2'h2);
  - function make_src_header(id) returning the header word.
- Sub-module rr_priority_picker (combinational):
  - inputs: request vector, last_grant;
  - outputs: any_req, pick_idx.
  - Reused by future RX demux/scheduler blocks.

Test Plan:
- After reset, src0 sends a 3-beat packet A0,A1,A2 with tlast on A2, tready=1 → dout_axis_tdata sequence A0,A1,A2. First tvalid appears 1 cycle after the request. busy drops the cycle after A2. grant_id=0.
- Sources 0, 1 and 3 continuously request 1-beat packets → grant order 0,1,3,0,1,3. One IDLE cycle between grants; source 2 is never granted.
- src2 streams 40 beats with no tlast, MAX_BURST=16, and src1 also requests → 16 beats from src2, then src1's packet, then src2 resumes for its next 16.
- src0 holds tvalid low for 5 cycles mid-packet while src1 requests → no src1 beat appears until src0's tlast beat. dout_axis_tvalid=0 during the stall.
- Transmitter tready toggles 1,0,0,1 during a packet → no duplicate or dropped words, and tdata is stable while tvalid && !tready.
- With UART_TX_ARBITER_SOURCE_ID_HEADER_EN defined and WORD_WIDTH=8, src3 sends 0x55 with tlast → dout sequence 0x83, then 0x55.
- rst_n pulsed low mid-STREAM → dout_axis_tvalid=0 and src_axis_tready=0 in the same cycle. After release, source 0 has first priority.
